lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
- REQ-001 Parameter XLEN, default 32, data width; legal values 32 and 64.
- REQ-002 Parameter ADDR_W, default 32, address width.
- REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
- REQ-004 Port rst, input, 1, asynchronous, active-high reset.
- REQ-005 Port req_valid, input, 1, core presents a load/store request.
- REQ-006 Port req_ready, output, 1, LSU accepts a request.
- REQ-007 Port req_we, input, 1: 1 = store, 0 = load.
- REQ-008 Port req_funct3, input, 3, RISC-V access size and sign code.
- REQ-009 Port req_addr, input, ADDR_W, byte address.
- REQ-010 Port req_wdata, input, XLEN, store data, right-aligned.
- REQ-011 Port resp_valid, output, 1, one-cycle completion pulse.
- REQ-012 Port resp_rdata, output, XLEN, extended load result; 0 for stores and errors.
- REQ-013 Port resp_misaligned, output, 1, address is not size-aligned; valid with resp_valid.
- REQ-014 Port resp_illegal, output, 1, funct3 is unsupported; valid with resp_valid.
- REQ-015 Ports mem_valid (output, 1) and mem_ready (input, 1), memory request handshake.
- REQ-016 Ports mem_we (output, 1), mem_addr (output, ADDR_W), mem_wstrb (output, XLEN/8) and mem_wdata (output, XLEN), memory request payload.
- REQ-017 Ports mem_rvalid (input, 1) and mem_rdata (input, XLEN), load return data.

Function
- REQ-018 The LSU SHALL implement states IDLE, REQ, WAIT and RESP. It SHALL hold one request at a time.
- REQ-019 req_ready SHALL be 1 only in IDLE. A request SHALL be captured when req_valid and req_ready are both 1.
- REQ-020 funct3 decode:
  - 000 = B, sign-extended
  - 001 = H, sign-extended
  - 010 = W, sign-extended
  - 011 = D; legal only when XLEN=64
  - 100 = BU
  - 101 = HU
  - 110 = WU; legal only when XLEN=64
  - 111 is always illegal.
  - For stores, funct3[2]=1 is illegal.
- REQ-021 Error priority: illegal is checked before misaligned.
- REQ-022 Misaligned means addr mod size_bytes is not 0.
- REQ-023 An illegal or misaligned request SHALL go IDLE->RESP with no mem_valid. It SHALL respond with the matching flag set and resp_rdata=0.
- REQ-024 A legal request SHALL go IDLE->REQ. In REQ, mem_valid SHALL be 1 with a stable payload until mem_ready=1.
- REQ-025 mem_addr SHALL be req_addr with the low log2(XLEN/8) bits cleared.
- REQ-026 Stores: off = addr mod (XLEN/8).
  - mem_wstrb = ((1<<size_bytes)-1) << off.
  - mem_wdata = req_wdata << (8*off).
  - On the handshake the LSU SHALL go REQ->RESP.
- REQ-027 Loads: on the handshake the LSU SHALL go REQ->WAIT.
  - In WAIT it SHALL stay until mem_rvalid=1.
  - It SHALL then register (mem_rdata >> 8*off), masked to size and sign- or zero-extended to XLEN.
  - It SHALL then go to RESP.
- REQ-028 In RESP, resp_valid SHALL be 1 for exactly one cycle, followed by a return to IDLE. req_ready is 0 during RESP.
- REQ-029 Minimum latency: load acceptance at cycle 0 with mem_ready=1 at cycle 1 and mem_rvalid=1 at cycle 2 gives resp_valid at cycle 3. For a store with mem_ready=1 at cycle 1, resp_valid SHALL be at cycle 2.
- REQ-030 mem_rvalid SHALL be ignored in IDLE, REQ and RESP.
- REQ-031 mem_ready SHALL be ignored outside REQ.
- REQ-032 mem_we, mem_wstrb and mem_wdata SHALL be 0 whenever mem_valid=0. mem_wstrb SHALL be 0 for loads.

Reset
- REQ-033 While rst=1, the LSU SHALL immediately (asynchronously) enter IDLE with these outputs:
  - req_ready=1
  - resp_valid=0
  - resp_rdata=0
  - resp_misaligned=0
  - resp_illegal=0
  - mem_valid=0
  - mem_we=0
  - mem_addr=0
  - mem_wstrb=0
  - mem_wdata=0
- REQ-034 Reset in REQ or WAIT SHALL abandon the access. A later mem_rvalid SHALL produce no response.

Verification
- REQ-035 XLEN=32, LB addr 0x1003, mem_rdata 0x80FF0000 -> resp_rdata 0xFFFFFF80, both flags 0, resp_valid 3 cycles after acceptance.
- REQ-036 XLEN=32, LHU addr 0x1002, mem_rdata 0xBEEF1234 -> resp_rdata 0x0000BEEF.
- REQ-037 XLEN=32, SB addr 0x2001, wdata 0x000000AB -> mem_addr 0x2000, mem_wstrb 4'b0010, mem_wdata 0x0000AB00, mem_we=1, resp_rdata 0.
- REQ-038 XLEN=32:
  - LW addr 0x1002 -> resp_misaligned=1, no mem_valid, response 1 cycle after acceptance.
  - LD funct3 011 -> resp_illegal=1.
- REQ-039 mem_ready held 0 for 5 cycles -> mem_valid and payload stable throughout, req_ready=0. Then rst pulse in WAIT -> mem_valid=0 and req_ready=1 immediately; a subsequent mem_rvalid gives no resp_valid.
- REQ-040 XLEN=64:
  - LWU addr 0x14, mem_rdata 0x89ABCDEF_00000000 -> resp_rdata 0x0000000089ABCDEF.
  - LD addr 0x10 -> full 64-bit word returned.

Source files
------------

// File: rtl/lsu_if.sv
// Core/memory-facing bus of the load/store unit: request, response and memory channels.
// The master side is the environment (core plus memory); the slave side is the LSU.
interface lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_misaligned;
  logic              resp_illegal;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
    input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
    output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// Single-outstanding RISC-V load/store unit: decodes size/sign, rejects illegal or
// misaligned accesses, aligns store data/strobes and extracts/extends load data.
module lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst,
  lsu_if.slave bus
);
  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]        state;
  logic [2:0]        funct3_r;
  logic              we_r;
  logic [OFF_W-1:0]  off_r;
  logic [ADDR_W-1:0] addr_r;
  logic [STRB_W-1:0] wstrb_r;
  logic [XLEN-1:0]   wdata_r;
  logic [XLEN-1:0]   rdata_r;
  logic              mis_r;
  logic              ill_r;

  logic              req_ill;
  logic              req_mis;
  logic [OFF_W-1:0]  req_off;
  logic [STRB_W-1:0] req_strb;
  logic [XLEN-1:0]   req_wdata_sh;
  logic [XLEN-1:0]   rdata_sh;

  function automatic logic [STRB_W-1:0] size_mask(input logic [1:0] sz);
    size_mask = '0;
    for (int i = 0; i < STRB_W; i++)
      size_mask[i] = (i < (1 << sz));
  endfunction

  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d, input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = d[7:0];
    h = d[15:0];
    w = d[31:0];
    case (f3[1:0])
      2'd0:    load_ext = f3[2] ? XLEN'(d[7:0])  : XLEN'(b);
      2'd1:    load_ext = f3[2] ? XLEN'(d[15:0]) : XLEN'(h);
      2'd2:    load_ext = f3[2] ? XLEN'(d[31:0]) : XLEN'(w);
      default: load_ext = d;
    endcase
  endfunction

  // Request decode: illegal takes priority over misaligned.
  always_comb begin
    req_off = bus.req_addr[OFF_W-1:0];
    req_ill = (bus.req_funct3 == 3'b111) ||
              (bus.req_we && bus.req_funct3[2]) ||
              ((XLEN != 64) && (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110));
    case (bus.req_funct3[1:0])
      2'd0:    req_mis = 1'b0;
      2'd1:    req_mis = bus.req_addr[0];
      2'd2:    req_mis = |bus.req_addr[1:0];
      default: req_mis = |bus.req_addr[2:0];
    endcase
    req_strb     = size_mask(bus.req_funct3[1:0]) << req_off;
    req_wdata_sh = bus.req_wdata << {req_off, 3'b000};
  end

  assign rdata_sh = bus.mem_rdata >> {off_r, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      funct3_r <= '0;
      we_r     <= 1'b0;
      off_r    <= '0;
      addr_r   <= '0;
      wstrb_r  <= '0;
      wdata_r  <= '0;
      rdata_r  <= '0;
      mis_r    <= 1'b0;
      ill_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            funct3_r <= bus.req_funct3;
            we_r     <= bus.req_we;
            off_r    <= req_off;
            addr_r   <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wstrb_r  <= bus.req_we ? req_strb : '0;
            wdata_r  <= bus.req_we ? req_wdata_sh : '0;
            rdata_r  <= '0;
            ill_r    <= req_ill;
            mis_r    <= !req_ill && req_mis;
            state    <= (req_ill || req_mis) ? RESP : REQ;
          end
        end
        REQ: begin
          if (bus.mem_ready)
            state <= we_r ? RESP : WAIT;
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            rdata_r <= load_ext(rdata_sh, funct3_r);
            state   <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-side payload is forced to zero whenever no memory request is presented.
  assign bus.req_ready       = (state == IDLE);
  assign bus.mem_valid       = (state == REQ);
  assign bus.mem_we          = bus.mem_valid && we_r;
  assign bus.mem_addr        = addr_r;
  assign bus.mem_wstrb       = bus.mem_valid ? wstrb_r : '0;
  assign bus.mem_wdata       = bus.mem_valid ? wdata_r : '0;
  assign bus.resp_valid      = (state == RESP);
  assign bus.resp_rdata      = rdata_r;
  assign bus.resp_misaligned = mis_r;
  assign bus.resp_illegal    = ill_r;
endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: one 32-bit and one 64-bit instance driven through a shared stimulus
// port, expected responses queued at issue and compared when resp_valid appears.
module tb_lsu;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  lsu_if #(.XLEN(32), .ADDR_W(32)) b32 ();
  lsu_if #(.XLEN(64), .ADDR_W(32)) b64 ();

  lsu #(.XLEN(32), .ADDR_W(32)) u_lsu32 (.clk(clk), .rst(rst), .bus(b32));
  lsu #(.XLEN(64), .ADDR_W(32)) u_lsu64 (.clk(clk), .rst(rst), .bus(b64));

  logic        sel;
  logic        req_valid, req_we, mem_ready, mem_rvalid;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, mem_rdata;

  assign b32.req_valid  = req_valid && !sel;
  assign b64.req_valid  = req_valid && sel;
  assign b32.req_we     = req_we;
  assign b64.req_we     = req_we;
  assign b32.req_funct3 = req_funct3;
  assign b64.req_funct3 = req_funct3;
  assign b32.req_addr   = req_addr;
  assign b64.req_addr   = req_addr;
  assign b32.req_wdata  = req_wdata[31:0];
  assign b64.req_wdata  = req_wdata;
  assign b32.mem_ready  = mem_ready && !sel;
  assign b64.mem_ready  = mem_ready && sel;
  assign b32.mem_rvalid = mem_rvalid && !sel;
  assign b64.mem_rvalid = mem_rvalid && sel;
  assign b32.mem_rdata  = mem_rdata[31:0];
  assign b64.mem_rdata  = mem_rdata;

  logic        o_req_ready, o_resp_valid, o_mis, o_ill, o_mem_valid, o_mem_we;
  logic [63:0] o_rdata, o_mem_wdata;
  logic [31:0] o_mem_addr;
  logic [7:0]  o_mem_wstrb;

  assign o_req_ready  = sel ? b64.req_ready       : b32.req_ready;
  assign o_resp_valid = sel ? b64.resp_valid      : b32.resp_valid;
  assign o_mis        = sel ? b64.resp_misaligned : b32.resp_misaligned;
  assign o_ill        = sel ? b64.resp_illegal    : b32.resp_illegal;
  assign o_mem_valid  = sel ? b64.mem_valid       : b32.mem_valid;
  assign o_mem_we     = sel ? b64.mem_we          : b32.mem_we;
  assign o_rdata      = sel ? b64.resp_rdata      : {32'h0, b32.resp_rdata};
  assign o_mem_wdata  = sel ? b64.mem_wdata       : {32'h0, b32.mem_wdata};
  assign o_mem_addr   = sel ? b64.mem_addr        : b32.mem_addr;
  assign o_mem_wstrb  = sel ? b64.mem_wstrb       : {4'h0, b32.mem_wstrb};

  typedef struct packed {
    logic [63:0] rdata;
    logic        mis;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic txn(input logic s, input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [63:0] wd, input logic [63:0] md, input int rdy_dly,
                     input int rv_dly, output logic [63:0] got);
    int nb, sz, off, lat, nv, nw;
    logic ill, mis, hs, seen_mv, done;
    logic [63:0] ld, ewd;
    logic [7:0]  estrb;
    logic [31:0] eaddr;
    exp_t e, o;
    nb    = s ? 8 : 4;
    sz    = 1 << f3[1:0];
    off   = int'(a[2:0]) % nb;
    ill   = (f3 == 3'd7) || (we && f3[2]) || (!s && (f3 == 3'd3 || f3 == 3'd6));
    mis   = !ill && ((int'(a[2:0]) % sz) != 0);
    eaddr = a & ~32'(nb - 1);
    estrb = '0;
    ewd   = '0;
    ld    = '0;
    for (int i = 0; i < nb; i++) begin
      if (we && i >= off && i < off + sz) estrb[i] = 1'b1;
      if (i >= off) ewd[8*i +: 8] = wd[8*(i-off) +: 8];
    end
    for (int j = 0; j < sz; j++)
      if (off + j < nb) ld[8*j +: 8] = md[8*(off+j) +: 8];
    if (!f3[2] && ld[8*sz-1])
      for (int j = sz; j < nb; j++) ld[8*j +: 8] = 8'hFF;
    e.rdata = (ill || mis || we) ? 64'h0 : ld;
    e.mis   = mis;
    e.ill   = ill;
    lat     = (ill || mis) ? 1 : (we ? 2 + rdy_dly : 3 + rdy_dly + rv_dly);
    sb.push_back(e);

    @(negedge clk);
    sel = s; req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    #1 chk("req_ready_idle", 64'(o_req_ready), 1);
    hs = 1'b0; seen_mv = 1'b0; done = 1'b0; nv = 0; nw = 0; got = '0;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clk);
      req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
      if (o_resp_valid) begin
        done = 1'b1;
        got  = o_rdata;
        chk("latency", 64'(k), 64'(lat));
        chk("mem_issued", 64'(seen_mv), 64'(!(ill || mis)));
        chk("sb_nonempty", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          o = sb.pop_front();
          chk("resp_rdata", o_rdata, o.rdata);
          chk("resp_misaligned", 64'(o_mis), 64'(o.mis));
          chk("resp_illegal", 64'(o_ill), 64'(o.ill));
        end
      end else begin
        chk("req_ready_busy", 64'(o_req_ready), 0);
        if (o_mem_valid) begin
          seen_mv = 1'b1;
          nv++;
          chk("mem_addr", 64'(o_mem_addr), 64'(eaddr));
          chk("mem_we", 64'(o_mem_we), 64'(we));
          chk("mem_wstrb", 64'(o_mem_wstrb), 64'(estrb));
          if (we) chk("mem_wdata", o_mem_wdata, ewd);
          if (nv > rdy_dly) begin
            mem_ready = 1'b1;
            hs = 1'b1;
          end else begin
            mem_rvalid = 1'b1;
          end
        end else begin
          chk("mem_idle_zero", 64'(o_mem_we || o_mem_wstrb != 8'h0 || o_mem_wdata != 64'h0), 0);
          if (hs && !we) begin
            nw++;
            if (nw > rv_dly) begin
              mem_rvalid = 1'b1;
              mem_rdata  = md;
            end
          end
        end
      end
    end
    chk("resp_seen", 64'(done), 1);
    if (!done && sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("resp_one_cycle", 64'(o_resp_valid), 0);
    chk("req_ready_after", 64'(o_req_ready), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(o_req_ready), 1);
    chk({tag, "_resp_valid"}, 64'(o_resp_valid), 0);
    chk({tag, "_resp_rdata"}, o_rdata, 0);
    chk({tag, "_flags"}, 64'({o_mis, o_ill}), 0);
    chk({tag, "_mem_valid"}, 64'(o_mem_valid), 0);
    chk({tag, "_mem_we"}, 64'(o_mem_we), 0);
    chk({tag, "_mem_addr"}, 64'(o_mem_addr), 0);
    chk({tag, "_mem_wstrb"}, 64'(o_mem_wstrb), 0);
    chk({tag, "_mem_wdata"}, o_mem_wdata, 0);
  endtask

  logic [63:0] got;

  initial begin
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #2 chk_reset_outputs("rst32");
    sel = 1'b1;
    #1 chk_reset_outputs("rst64");
    @(negedge clk);
    rst = 1'b0;

    txn(1'b0, 1'b0, 3'd0, 32'h1003, 64'h0, 64'h80FF0000, 0, 0, got);
    chk("lb_sign", got, 64'hFFFFFF80);
    txn(1'b0, 1'b0, 3'd5, 32'h1002, 64'h0, 64'hBEEF1234, 0, 0, got);
    chk("lhu_zero", got, 64'h0000BEEF);
    txn(1'b0, 1'b1, 3'd0, 32'h2001, 64'hAB, 64'h0, 0, 0, got);
    chk("sb_rdata", got, 64'h0);
    txn(1'b0, 1'b0, 3'd2, 32'h1002, 64'h0, 64'h0, 0, 0, got);
    txn(1'b0, 1'b0, 3'd3, 32'h1000, 64'h0, 64'h0, 0, 0, got);
    txn(1'b0, 1'b0, 3'd7, 32'h1001, 64'h0, 64'h0, 0, 0, got);
    txn(1'b0, 1'b1, 3'd4, 32'h1000, 64'h55, 64'h0, 0, 0, got);
    txn(1'b0, 1'b0, 3'd1, 32'h1006, 64'h0, 64'h8001_0000, 0, 0, got);
    chk("lh_sign", got, 64'hFFFF8001);
    txn(1'b0, 1'b1, 3'd2, 32'h3000, 64'hCAFEF00D, 64'h0, 3, 0, got);
    txn(1'b0, 1'b0, 3'd2, 32'h4004, 64'h0, 64'h7654_3210, 2, 3, got);
    chk("lw_delayed", got, 64'h76543210);
    txn(1'b0, 1'b1, 3'd1, 32'h2002, 64'h1234, 64'h0, 1, 0, got);
    txn(1'b1, 1'b0, 3'd6, 32'h14, 64'h0, 64'h89ABCDEF_00000000, 0, 0, got);
    chk("lwu64", got, 64'h0000000089ABCDEF);
    txn(1'b1, 1'b0, 3'd3, 32'h10, 64'h0, 64'h01234567_89ABCDEF, 0, 0, got);
    chk("ld64", got, 64'h0123456789ABCDEF);
    txn(1'b1, 1'b0, 3'd2, 32'h1C, 64'h0, 64'hF0000000_00000000, 0, 1, got);
    chk("lw64_sign", got, 64'hFFFFFFFFF0000000);
    txn(1'b1, 1'b1, 3'd3, 32'h18, 64'h11223344_55667788, 64'h0, 0, 0, got);
    txn(1'b1, 1'b1, 3'd0, 32'h17, 64'hEE, 64'h0, 0, 0, got);
    txn(1'b1, 1'b0, 3'd1, 32'h13, 64'h0, 64'h0, 0, 0, got);
    txn(1'b1, 1'b1, 3'd6, 32'h10, 64'h0, 64'h0, 0, 0, got);

    for (int n = 0; n < 30; n++) begin
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          $urandom & 32'hFFFF, {$urandom, $urandom}, {$urandom, $urandom},
          $urandom_range(0, 2), $urandom_range(0, 2), got);
    end

    // Stalled memory, then reset while waiting for load data.
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h5008;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_mem_valid", 64'(o_mem_valid), 1);
      chk("stall_mem_addr", 64'(o_mem_addr), 64'h5008);
      chk("stall_mem_wstrb", 64'(o_mem_wstrb), 0);
      chk("stall_req_ready", 64'(o_req_ready), 0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("wait_mem_valid", 64'(o_mem_valid), 0);
    chk("wait_req_ready", 64'(o_req_ready), 0);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 64'h1234_5678;
      @(negedge clk);
      chk("no_resp_after_rst", 64'(o_resp_valid), 0);
    end
    mem_rvalid = 1'b0;
    chk("idle_after_rst", 64'(o_req_ready), 1);
    txn(1'b0, 1'b0, 3'd4, 32'h6001, 64'h0, 64'h0000_9C00, 0, 0, got);
    chk("lbu_after_rst", got, 64'h9C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
